// File: rtl/wts_noise_register_4ch_pkg.sv
// Register map constants and FSM state type shared by the noise register file
// and its per-channel byte registers.
package wts_noise_regmap;

  localparam logic [3:0] ADDR_CH_A      = 4'h0;
  localparam logic [3:0] ADDR_CH_E      = 4'h4;
  localparam logic [3:0] ADDR_FREQ_BASE = 4'h5;
  localparam logic [3:0] ADDR_FREQ_LAST = 4'h8;

  localparam int BIT_EN1     = 7;
  localparam int BIT_SEL1_HI = 5;
  localparam int BIT_SEL1_LO = 4;
  localparam int BIT_EN0     = 3;
  localparam int BIT_SEL0_HI = 1;
  localparam int BIT_SEL0_LO = 0;

  // Bits 6 and 2 of a channel byte are not stored and read back as 0.
  localparam logic [7:0] CH_MASK     = 8'hBB;
  localparam logic [7:0] UNMAPPED_RD = 8'hFF;
  localparam logic [2:0] CPU_SLOT    = 3'd5;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

endpackage

// File: rtl/wts_noise_register_4ch_if.sv
// CPU request/response bus of the noise register file.
// Handshake: a request (wrreq or rdreq) is taken only in a cycle where busy is 0;
// busy stays 1 until the request commits in a CPU slot, and a read completes with
// a single-cycle rddata_en pulse while rddata holds the value.
interface wts_noise_register_4ch_if;
  logic       wrreq;
  logic       rdreq;
  logic [3:0] address;
  logic [7:0] wrdata;
  logic [7:0] rddata;
  logic       rddata_en;
  logic       busy;

  modport master (
    output wrreq, rdreq, address, wrdata,
    input  rddata, rddata_en, busy
  );

  modport slave (
    input  wrreq, rdreq, address, wrdata,
    output rddata, rddata_en, busy
  );
endinterface

// File: rtl/wts_noise_register_4ch_channel_reg.sv
// One channel byte (enable/select pairs for noise outputs 0 and 1).
module wts_noise_channel_reg
  import wts_noise_regmap::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       we_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rd_byte_o,
  output logic       en0_o,
  output logic [1:0] sel0_o,
  output logic       en1_o,
  output logic [1:0] sel1_o
);

  logic [7:0] byte_q, byte_d;

  always_comb begin
    byte_d = byte_q;
    if (we_i) byte_d = wdata_i & CH_MASK;
  end

  always_ff @(posedge clk) begin
    if (reset) byte_q <= '0;
    else       byte_q <= byte_d;
  end

  assign rd_byte_o = byte_q;
  assign en0_o     = byte_q[BIT_EN0];
  assign sel0_o    = byte_q[BIT_SEL0_HI:BIT_SEL0_LO];
  assign en1_o     = byte_q[BIT_EN1];
  assign sel1_o    = byte_q[BIT_SEL1_HI:BIT_SEL1_LO];

endmodule

// File: rtl/wts_noise_register_4ch.sv
// CPU-side register file for the 4-channel noise generator; one-deep request
// buffer that commits only in the CPU slot so noise settings never change mid-slot.
module wts_noise_register_4ch
  import wts_noise_regmap::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] active,
  wts_noise_register_4ch_if.slave cpu,
  output state_e     state_dbg,
  output logic       reg_noise_enable_a0, reg_noise_enable_a1,
  output logic       reg_noise_enable_b0, reg_noise_enable_b1,
  output logic       reg_noise_enable_c0, reg_noise_enable_c1,
  output logic       reg_noise_enable_d0, reg_noise_enable_d1,
  output logic       reg_noise_enable_e0, reg_noise_enable_e1,
  output logic [1:0] reg_noise_sel_a0, reg_noise_sel_a1,
  output logic [1:0] reg_noise_sel_b0, reg_noise_sel_b1,
  output logic [1:0] reg_noise_sel_c0, reg_noise_sel_c1,
  output logic [1:0] reg_noise_sel_d0, reg_noise_sel_d1,
  output logic [1:0] reg_noise_sel_e0, reg_noise_sel_e1,
  output logic [4:0] reg_noise_frequency0, reg_noise_frequency1,
  output logic [4:0] reg_noise_frequency2, reg_noise_frequency3
);

  state_e     state_q, state_d;
  logic       capture, commit;
  logic [3:0] pend_addr_q;
  logic [7:0] pend_data_q;
  logic       pend_wr_q;
  logic [7:0] rddata_q;
  logic       rddata_en_q;
  logic [4:0] freq_q [4];
  logic [7:0] rd_val;

  logic [4:0] ch_we;
  logic [7:0] ch_byte [5];
  logic [4:0] en0_w, en1_w;
  logic [1:0] sel0_w [5];
  logic [1:0] sel1_w [5];

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // A capture never commits in its own cycle: commit is only decoded in PENDING.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu.wrreq || cpu.rdreq) begin
          capture = 1'b1;
          state_d = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (active == CPU_SLOT) begin
          commit  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_val = UNMAPPED_RD;
    case (pend_addr_q)
      4'h0: rd_val = ch_byte[0];
      4'h1: rd_val = ch_byte[1];
      4'h2: rd_val = ch_byte[2];
      4'h3: rd_val = ch_byte[3];
      4'h4: rd_val = ch_byte[4];
      4'h5: rd_val = {3'b000, freq_q[0]};
      4'h6: rd_val = {3'b000, freq_q[1]};
      4'h7: rd_val = {3'b000, freq_q[2]};
      4'h8: rd_val = {3'b000, freq_q[3]};
      default: rd_val = UNMAPPED_RD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_addr_q <= '0;
      pend_data_q <= '0;
      pend_wr_q   <= 1'b0;
      rddata_q    <= '0;
      rddata_en_q <= 1'b0;
      for (int i = 0; i < 4; i++) freq_q[i] <= '0;
    end else begin
      rddata_en_q <= 1'b0;
      // Write wins when both requests arrive together.
      if (capture) begin
        pend_addr_q <= cpu.address;
        pend_data_q <= cpu.wrdata;
        pend_wr_q   <= cpu.wrreq;
      end
      if (commit && pend_wr_q) begin
        case (pend_addr_q)
          4'h5: freq_q[0] <= pend_data_q[4:0];
          4'h6: freq_q[1] <= pend_data_q[4:0];
          4'h7: freq_q[2] <= pend_data_q[4:0];
          4'h8: freq_q[3] <= pend_data_q[4:0];
          default: ;
        endcase
      end
      if (commit && !pend_wr_q) begin
        rddata_q    <= rd_val;
        rddata_en_q <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < 5; g++) begin : g_ch
    assign ch_we[g] = commit && pend_wr_q && (pend_addr_q == (ADDR_CH_A + 4'(g)));
    wts_noise_channel_reg u_ch (
      .clk       (clk),
      .reset     (reset),
      .we_i      (ch_we[g]),
      .wdata_i   (pend_data_q),
      .rd_byte_o (ch_byte[g]),
      .en0_o     (en0_w[g]),
      .sel0_o    (sel0_w[g]),
      .en1_o     (en1_w[g]),
      .sel1_o    (sel1_w[g])
    );
  end

  assign cpu.rddata    = rddata_q;
  assign cpu.rddata_en = rddata_en_q;
  assign cpu.busy      = (state_q == ST_PENDING);
  assign state_dbg     = state_q;

  assign reg_noise_enable_a0 = en0_w[0];
  assign reg_noise_enable_a1 = en1_w[0];
  assign reg_noise_enable_b0 = en0_w[1];
  assign reg_noise_enable_b1 = en1_w[1];
  assign reg_noise_enable_c0 = en0_w[2];
  assign reg_noise_enable_c1 = en1_w[2];
  assign reg_noise_enable_d0 = en0_w[3];
  assign reg_noise_enable_d1 = en1_w[3];
  assign reg_noise_enable_e0 = en0_w[4];
  assign reg_noise_enable_e1 = en1_w[4];
  assign reg_noise_sel_a0    = sel0_w[0];
  assign reg_noise_sel_a1    = sel1_w[0];
  assign reg_noise_sel_b0    = sel0_w[1];
  assign reg_noise_sel_b1    = sel1_w[1];
  assign reg_noise_sel_c0    = sel0_w[2];
  assign reg_noise_sel_c1    = sel1_w[2];
  assign reg_noise_sel_d0    = sel0_w[3];
  assign reg_noise_sel_d1    = sel1_w[3];
  assign reg_noise_sel_e0    = sel0_w[4];
  assign reg_noise_sel_e1    = sel1_w[4];

  assign reg_noise_frequency0 = freq_q[0];
  assign reg_noise_frequency1 = freq_q[1];
  assign reg_noise_frequency2 = freq_q[2];
  assign reg_noise_frequency3 = freq_q[3];

endmodule

// File: tb/tb_wts_noise_register_4ch.sv
// Directed bench for the noise register file: register map, CPU-slot commit timing,
// write-wins arbitration, busy-drop of requests and reset of a pending request.
module tb_wts_noise_register_4ch;
  import wts_noise_regmap::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] active = 3'd0;
  logic [2:0] act_cnt = 3'd0;
  state_e     state_dbg;

  logic       en_a0, en_a1, en_b0, en_b1, en_c0, en_c1, en_d0, en_d1, en_e0, en_e1;
  logic [1:0] sel_a0, sel_a1, sel_b0, sel_b1, sel_c0, sel_c1, sel_d0, sel_d1, sel_e0, sel_e1;
  logic [4:0] fq0, fq1, fq2, fq3;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] m_ch [5];
  logic [4:0] m_fq [4];
  logic [7:0] last_rd;
  logic [7:0] exp_q [$];
  logic [7:0] obs_ch [5];
  logic [4:0] obs_fq [4];

  wts_noise_register_4ch_if cpu ();

  always #5 clk = ~clk;

  wts_noise_register_4ch dut (
    .clk (clk), .reset (reset), .active (active), .cpu (cpu), .state_dbg (state_dbg),
    .reg_noise_enable_a0 (en_a0), .reg_noise_enable_a1 (en_a1),
    .reg_noise_enable_b0 (en_b0), .reg_noise_enable_b1 (en_b1),
    .reg_noise_enable_c0 (en_c0), .reg_noise_enable_c1 (en_c1),
    .reg_noise_enable_d0 (en_d0), .reg_noise_enable_d1 (en_d1),
    .reg_noise_enable_e0 (en_e0), .reg_noise_enable_e1 (en_e1),
    .reg_noise_sel_a0 (sel_a0), .reg_noise_sel_a1 (sel_a1),
    .reg_noise_sel_b0 (sel_b0), .reg_noise_sel_b1 (sel_b1),
    .reg_noise_sel_c0 (sel_c0), .reg_noise_sel_c1 (sel_c1),
    .reg_noise_sel_d0 (sel_d0), .reg_noise_sel_d1 (sel_d1),
    .reg_noise_sel_e0 (sel_e0), .reg_noise_sel_e1 (sel_e1),
    .reg_noise_frequency0 (fq0), .reg_noise_frequency1 (fq1),
    .reg_noise_frequency2 (fq2), .reg_noise_frequency3 (fq3)
  );

  // Reassemble each channel's outputs into its register-map byte.
  assign obs_ch[0] = {en_a1, 1'b0, sel_a1, en_a0, 1'b0, sel_a0};
  assign obs_ch[1] = {en_b1, 1'b0, sel_b1, en_b0, 1'b0, sel_b0};
  assign obs_ch[2] = {en_c1, 1'b0, sel_c1, en_c0, 1'b0, sel_c0};
  assign obs_ch[3] = {en_d1, 1'b0, sel_d1, en_d0, 1'b0, sel_d0};
  assign obs_ch[4] = {en_e1, 1'b0, sel_e1, en_e0, 1'b0, sel_e0};
  assign obs_fq[0] = fq0;
  assign obs_fq[1] = fq1;
  assign obs_fq[2] = fq2;
  assign obs_fq[3] = fq3;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    active = act_cnt;
    @(posedge clk);
    #1;
    act_cnt = act_cnt + 3'd1;
  endtask

  function automatic logic [7:0] model_read(input logic [3:0] addr);
    if (addr <= 4'h4)      return m_ch[addr] & 8'hBB;
    else if (addr <= 4'h8) return {3'b000, m_fq[addr - 4'h5]};
    else                   return 8'hFF;
  endfunction

  task automatic check_regs(input string tag);
    for (int i = 0; i < 5; i++) check_eq($sformatf("%s_ch%0d", tag, i), 32'(obs_ch[i]), 32'(m_ch[i] & 8'hBB));
    for (int i = 0; i < 4; i++) check_eq($sformatf("%s_fq%0d", tag, i), 32'(obs_fq[i]), 32'(m_fq[i]));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) m_ch[i] = 8'h00;
    for (int i = 0; i < 4; i++) m_fq[i] = 5'd0;
    last_rd = 8'h00;
  endtask

  // One CPU access; optionally fires a second write (to 0x8) while busy.
  task automatic access(input logic wr, input logic rd, input logic [3:0] addr,
                        input logic [7:0] data, input logic intrude);
    logic [2:0] cur;
    logic       done;
    logic [7:0] exp_rd;
    done = 1'b0;
    cpu.wrreq = wr; cpu.rdreq = rd; cpu.address = addr; cpu.wrdata = data;
    tick();
    cpu.wrreq = 1'b0; cpu.rdreq = 1'b0;
    check_eq("busy_after_capture", 32'(cpu.busy), 32'd1);
    for (int i = 0; i < 16 && !done; i++) begin
      if (intrude && i == 0) begin
        cpu.wrreq = 1'b1; cpu.address = 4'h8; cpu.wrdata = 8'h15;
      end
      cur = act_cnt;
      tick();
      cpu.wrreq = 1'b0;
      if (cur == CPU_SLOT) begin
        done = 1'b1;
      end else begin
        check_eq("busy_waiting", 32'(cpu.busy), 32'd1);
        check_eq("rden_waiting", 32'(cpu.rddata_en), 32'd0);
        check_regs("hold");
      end
    end
    check_eq("commit_seen", 32'(done), 32'd1);
    if (wr) begin
      if (addr <= 4'h4) m_ch[addr] = data;
      else if (addr <= 4'h8) m_fq[addr - 4'h5] = data[4:0];
    end else begin
      exp_q.push_back(model_read(addr));
    end
    check_eq("busy_after_commit", 32'(cpu.busy), 32'd0);
    check_eq("rden_after_commit", 32'(cpu.rddata_en), 32'(rd && !wr));
    if (!wr && exp_q.size() > 0) begin
      exp_rd = exp_q.pop_front();
      check_eq($sformatf("rddata_a%0h", addr), 32'(cpu.rddata), 32'(exp_rd));
      last_rd = exp_rd;
    end else begin
      check_eq("rddata_hold", 32'(cpu.rddata), 32'(last_rd));
    end
    check_regs("post");
    tick();
    check_eq("rden_one_cycle", 32'(cpu.rddata_en), 32'd0);
    check_eq("busy_stays_low", 32'(cpu.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cpu.wrreq = 1'b0; cpu.rdreq = 1'b0; cpu.address = 4'h0; cpu.wrdata = 8'h00;
    model_reset();
    tick();
    tick();
    check_eq("rst_busy", 32'(cpu.busy), 32'd0);
    check_eq("rst_rden", 32'(cpu.rddata_en), 32'd0);
    check_eq("rst_rddata", 32'(cpu.rddata), 32'd0);
    check_eq("rst_state", 32'(state_dbg), 32'd0);
    check_regs("rst");
    reset = 1'b0;

    // Sweep reads across the whole map.
    for (int a = 0; a < 16; a++) access(1'b0, 1'b1, 4'(a), 8'h00, 1'b0);

    // Channel C write from slot 0, then readback.
    act_cnt = 3'd0;
    access(1'b1, 1'b0, 4'h2, 8'hB9, 1'b0);
    check_eq("c1_en", 32'(en_c1), 32'd1);
    check_eq("c1_sel", 32'(sel_c1), 32'd3);
    check_eq("c0_en", 32'(en_c0), 32'd1);
    check_eq("c0_sel", 32'(sel_c0), 32'd1);
    access(1'b0, 1'b1, 4'h2, 8'h00, 1'b0);
    check_eq("rd_c_value", 32'(last_rd), 32'hB9);

    // Frequency2 saturating pattern; best-case capture at slot 4.
    act_cnt = 3'd4;
    access(1'b1, 1'b0, 4'h7, 8'hFF, 1'b0);
    check_eq("fq2_31", 32'(fq2), 32'd31);
    access(1'b0, 1'b1, 4'h7, 8'h00, 1'b0);
    check_eq("rd_fq2", 32'(last_rd), 32'h1F);

    // Capture in the CPU slot itself waits a full period.
    act_cnt = 3'd5;
    access(1'b1, 1'b0, 4'h0, 8'hFF, 1'b0);
    access(1'b0, 1'b1, 4'h0, 8'h00, 1'b0);
    check_eq("rd_a_masked", 32'(last_rd), 32'hBB);

    // Simultaneous write+read: write wins; intruding write while busy is dropped.
    act_cnt = 3'd6;
    access(1'b1, 1'b1, 4'h5, 8'h0A, 1'b1);
    check_eq("fq0_10", 32'(fq0), 32'd10);
    check_eq("fq3_untouched", 32'(fq3), 32'd0);

    // Unmapped write discarded; E channel and frequency3 patterns.
    access(1'b1, 1'b0, 4'hC, 8'h5A, 1'b0);
    access(1'b1, 1'b0, 4'h4, 8'h46, 1'b0);
    access(1'b1, 1'b0, 4'h8, 8'hE3, 1'b0);
    access(1'b0, 1'b1, 4'h4, 8'h00, 1'b0);
    check_eq("rd_e", 32'(last_rd), 32'h02);
    access(1'b0, 1'b1, 4'hC, 8'h00, 1'b0);
    check_eq("rd_unmapped", 32'(last_rd), 32'hFF);

    // Reset while a write to channel A is pending.
    act_cnt = 3'd0;
    cpu.wrreq = 1'b1; cpu.address = 4'h0; cpu.wrdata = 8'h88;
    tick();
    cpu.wrreq = 1'b0;
    check_eq("pend_busy", 32'(cpu.busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    check_eq("mid_rst_busy", 32'(cpu.busy), 32'd0);
    check_eq("mid_rst_state", 32'(state_dbg), 32'd0);
    check_eq("mid_rst_rddata", 32'(cpu.rddata), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("no_rden_after_rst", 32'(cpu.rddata_en), 32'd0);
      check_eq("idle_after_rst", 32'(cpu.busy), 32'd0);
    end
    check_regs("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
